simt_pc: RTL and testbench

- Per-core program counter with branch-divergence support. It replaces the per-thread PC instances with one shared PC plus per-thread NZP registers.
- Tracks a thread active mask and a reconvergence stack, so threads in a block may take different BRnzp directions and rejoin at a SYNC instruction.
- Sits between the decoder, the per-thread ALUs and the core scheduler. The scheduler feeds `next_pc` back as `current_pc` and gates thread writeback with `active_mask`.

---
 rtl/simt_pc.sv | 159 +++++++++++++++
 tb/tb_simt_pc.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/simt_pc.sv
// Shared program counter for a SIMT core: one PC, per-lane NZP flags, an active
// lane mask and a reconvergence stack so divergent BRnzp paths rejoin at SYNC.
module simt_pc #(
    parameter int THREADS_PER_BLOCK     = 4,
    parameter int DATA_MEM_DATA_BITS    = 8,
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int STACK_DEPTH           = 4
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            enable,
    input  logic [2:0]                                      core_state,
    input  logic [THREADS_PER_BLOCK-1:0]                    thread_enable,
    input  logic [2:0]                                      decoded_nzp,
    input  logic [DATA_MEM_DATA_BITS-1:0]                   decoded_immediate,
    input  logic                                            decoded_nzp_write_enable,
    input  logic                                            decoded_pc_mux,
    input  logic                                            decoded_sync,
    input  logic [THREADS_PER_BLOCK*DATA_MEM_DATA_BITS-1:0] alu_out,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0]                current_pc,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0]                next_pc,
    output logic [THREADS_PER_BLOCK-1:0]                    active_mask,
    output logic [$clog2(STACK_DEPTH+1)-1:0]                stack_depth,
    output logic                                            stack_overflow
);

    localparam int T  = THREADS_PER_BLOCK;
    localparam int W  = DATA_MEM_DATA_BITS;
    localparam int A  = PROGRAM_MEM_ADDR_BITS;
    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int AW = $clog2(STACK_DEPTH);

    localparam logic [2:0] EXECUTE = 3'b101;
    localparam logic [2:0] UPDATE  = 3'b110;

    logic [A-1:0]  next_pc_q, next_pc_d;
    logic [T-1:0]  mask_q, mask_d;
    logic [DW-1:0] depth_q, depth_d;
    logic          overflow_q, overflow_d;
    logic [2:0]    nzp_q [T];

    logic [A-1:0]  stack_pc_q     [STACK_DEPTH];
    logic [T-1:0]  stack_mask_q   [STACK_DEPTH];
    logic          stack_rejoin_q [STACK_DEPTH];

    logic [T-1:0]  eff;
    logic [T-1:0]  taken;
    logic [A-1:0]  imm;
    logic [A-1:0]  pc_plus1;
    logic [AW-1:0] top_idx;
    logic [AW-1:0] push_idx;
    logic          push;
    logic          pop;
    logic          room_for_two;
    logic          unused_bits;

    assign eff          = mask_q & thread_enable;
    assign pc_plus1     = current_pc + 1'b1;
    assign top_idx      = AW'(depth_q - DW'(1));
    assign push_idx     = AW'(depth_q);
    assign room_for_two = (depth_q <= DW'(STACK_DEPTH - 2));
    assign unused_bits  = ^{alu_out, decoded_immediate};

    generate
        if (W >= A) begin : g_imm_slice
            assign imm = decoded_immediate[A-1:0];
        end else begin : g_imm_zext
            assign imm = {{(A - W){1'b0}}, decoded_immediate};
        end
    endgenerate

    // Per-lane NZP flags and branch outcome.
    genvar gi;
    generate
        for (gi = 0; gi < T; gi++) begin : g_lane
            assign taken[gi] = eff[gi] & |(nzp_q[gi] & decoded_nzp);

            always_ff @(posedge clk) begin
                if (!reset) begin
                    nzp_q[gi] <= 3'b000;
                end else if (enable && core_state == UPDATE
                             && decoded_nzp_write_enable && eff[gi]) begin
                    nzp_q[gi] <= alu_out[gi*W +: 3];
                end
            end
        end
    endgenerate

    always_comb begin
        next_pc_d  = next_pc_q;
        mask_d     = mask_q;
        depth_d    = depth_q;
        overflow_d = overflow_q;
        push       = 1'b0;
        pop        = 1'b0;
        if (core_state == EXECUTE) begin
            next_pc_d = pc_plus1;
            if (decoded_sync) begin
                if (depth_q != '0) begin
                    pop     = 1'b1;
                    depth_d = depth_q - DW'(1);
                    mask_d  = stack_mask_q[top_idx];
                    if (!stack_rejoin_q[top_idx]) begin
                        next_pc_d = stack_pc_q[top_idx];
                    end
                end
            end else if (decoded_pc_mux) begin
                if (taken == eff) begin
                    next_pc_d = imm;
                end else if (taken != '0) begin
                    // Divergent: run the taken lanes first, park the rest.
                    if (room_for_two) begin
                        push      = 1'b1;
                        depth_d   = depth_q + DW'(2);
                        next_pc_d = imm;
                        mask_d    = taken;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            next_pc_q  <= '0;
            mask_q     <= '1;
            depth_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_pc_q[i]     <= '0;
                stack_mask_q[i]   <= '0;
                stack_rejoin_q[i] <= 1'b0;
            end
        end else if (enable) begin
            next_pc_q  <= next_pc_d;
            mask_q     <= mask_d;
            depth_q    <= depth_d;
            overflow_q <= overflow_d;
            if (push) begin
                stack_pc_q[push_idx]              <= '0;
                stack_mask_q[push_idx]            <= mask_q;
                stack_rejoin_q[push_idx]          <= 1'b1;
                stack_pc_q[push_idx + AW'(1)]     <= pc_plus1;
                stack_mask_q[push_idx + AW'(1)]   <= eff & ~taken;
                stack_rejoin_q[push_idx + AW'(1)] <= 1'b0;
            end else if (pop) begin
                stack_rejoin_q[top_idx] <= 1'b0;
            end
        end
    end

    assign next_pc        = next_pc_q;
    assign active_mask    = mask_q;
    assign stack_depth    = depth_q;
    assign stack_overflow = overflow_q;

endmodule

// File: tb/tb_simt_pc.sv
// Directed bench for simt_pc: a queue-based reference model checked every cycle,
// plus literal expectations taken from hand-worked scenarios.
module tb_simt_pc;

    typedef struct {
        bit         rejoin;
        logic [7:0] pc;
        logic [3:0] mask;
    } entry_t;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [2:0]  core_state;
    logic [3:0]  thread_enable;
    logic [2:0]  decoded_nzp;
    logic [7:0]  decoded_immediate;
    logic        decoded_nzp_write_enable;
    logic        decoded_pc_mux;
    logic        decoded_sync;
    logic [31:0] alu_out;
    logic [7:0]  current_pc;
    logic [7:0]  next_pc;
    logic [3:0]  active_mask;
    logic [2:0]  stack_depth;
    logic        stack_overflow;

    simt_pc dut (
        .clk                      (clk),
        .reset                    (reset),
        .enable                   (enable),
        .core_state               (core_state),
        .thread_enable            (thread_enable),
        .decoded_nzp              (decoded_nzp),
        .decoded_immediate        (decoded_immediate),
        .decoded_nzp_write_enable (decoded_nzp_write_enable),
        .decoded_pc_mux           (decoded_pc_mux),
        .decoded_sync             (decoded_sync),
        .alu_out                  (alu_out),
        .current_pc               (current_pc),
        .next_pc                  (next_pc),
        .active_mask              (active_mask),
        .stack_depth              (stack_depth),
        .stack_overflow           (stack_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] m_pc;
    logic [3:0] m_mask;
    bit         m_ovf;
    entry_t     m_stk[$];
    logic [2:0] m_nzp[4];

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_on  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_pc", {24'd0, next_pc}, {24'd0, m_pc});
            chk("model_mask", {28'd0, active_mask}, {28'd0, m_mask});
            chk("model_depth", {29'd0, stack_depth}, m_stk.size());
            chk("model_ovf", {31'd0, stack_overflow}, {31'd0, m_ovf});
        end
    end

    // Apply the current inputs for one clock, advancing the model alongside.
    task automatic step(input string tag);
        logic [7:0] n_pc, pc1;
        logic [3:0] n_mask, eff, taken;
        bit         n_ovf;
        entry_t     n_stk[$];
        entry_t     e;
        logic [2:0] n_nzp[4];
        n_pc = m_pc; n_mask = m_mask; n_ovf = m_ovf; n_stk = m_stk; n_nzp = m_nzp;
        pc1 = current_pc + 8'd1;
        if (!reset) begin
            n_pc = 8'd0; n_mask = 4'hF; n_ovf = 0; n_stk.delete();
            for (int i = 0; i < 4; i++) n_nzp[i] = 3'd0;
        end else if (enable) begin
            eff = m_mask & thread_enable;
            if (core_state == 3'b110 && decoded_nzp_write_enable)
                for (int t = 0; t < 4; t++) if (eff[t]) n_nzp[t] = alu_out[t*8 +: 3];
            if (core_state == 3'b101) begin
                n_pc = pc1;
                if (decoded_sync) begin
                    if (m_stk.size() > 0) begin
                        e = m_stk[$];
                        n_stk.pop_back();
                        n_mask = e.mask;
                        if (!e.rejoin) n_pc = e.pc;
                    end
                end else if (decoded_pc_mux) begin
                    for (int t = 0; t < 4; t++)
                        taken[t] = eff[t] && ((m_nzp[t] & decoded_nzp) != 3'd0);
                    if (taken == eff) n_pc = decoded_immediate;
                    else if (taken != 4'd0) begin
                        if (m_stk.size() + 2 <= 4) begin
                            e.rejoin = 1; e.pc = 8'd0; e.mask = m_mask;
                            n_stk.push_back(e);
                            e.rejoin = 0; e.pc = pc1; e.mask = eff & ~taken;
                            n_stk.push_back(e);
                            n_pc = decoded_immediate;
                            n_mask = taken;
                        end else n_ovf = 1;
                    end
                end
            end
        end
        @(posedge clk);
        m_pc = n_pc; m_mask = n_mask; m_ovf = n_ovf; m_stk = n_stk; m_nzp = n_nzp;
        #1;
        $display("%-10s pc_in=%02h -> next_pc=%02h mask=%b depth=%0d ovf=%0b",
                 tag, current_pc, next_pc, active_mask, stack_depth, stack_overflow);
    endtask

    task automatic idle_inputs();
        core_state = 3'b000; decoded_nzp = 3'd0; decoded_immediate = 8'd0;
        decoded_nzp_write_enable = 0; decoded_pc_mux = 0; decoded_sync = 0;
    endtask

    task automatic do_cmp(input logic [2:0] l0, input logic [2:0] l1,
                          input logic [2:0] l2, input logic [2:0] l3);
        idle_inputs();
        core_state = 3'b110; decoded_nzp_write_enable = 1;
        alu_out = {5'h1F, l3, 5'h15, l2, 5'h0A, l1, 5'h1F, l0};
        step("cmp");
        idle_inputs();
    endtask

    task automatic do_exec(input string tag, input logic [7:0] pc, input bit br,
                           input bit sy, input logic [2:0] nzp, input logic [7:0] imm);
        idle_inputs();
        core_state = 3'b101; current_pc = pc; decoded_pc_mux = br;
        decoded_sync = sy; decoded_nzp = nzp; decoded_immediate = imm;
        step(tag);
        idle_inputs();
    endtask

    task automatic expect_out(input string tag, input logic [7:0] pc, input logic [3:0] mask,
                              input int depth, input bit ovf);
        chk({tag, "_pc"}, {24'd0, next_pc}, {24'd0, pc});
        chk({tag, "_mask"}, {28'd0, active_mask}, {28'd0, mask});
        chk({tag, "_depth"}, {29'd0, stack_depth}, depth);
        chk({tag, "_ovf"}, {31'd0, stack_overflow}, {31'd0, ovf});
    endtask

    initial begin
        idle_inputs();
        reset = 0; enable = 1; thread_enable = 4'hF; alu_out = 32'd0; current_pc = 8'd0;
        m_pc = 8'hAA; m_mask = 4'h0; m_ovf = 0;
        for (int i = 0; i < 4; i++) m_nzp[i] = 3'd7;
        step("reset");
        step("reset");
        cmp_on = 1;
        expect_out("reset", 8'h00, 4'hF, 0, 0);
        reset = 1;
        step("idle");

        // Uniform branch
        do_cmp(3'b010, 3'b010, 3'b010, 3'b010);
        do_exec("br_unif", 8'h05, 1, 0, 3'b010, 8'h20);
        expect_out("uniform", 8'h20, 4'hF, 0, 0);

        // Divergence and reconvergence
        do_cmp(3'b100, 3'b100, 3'b001, 3'b001);
        do_exec("br_div", 8'h05, 1, 0, 3'b100, 8'h10);
        expect_out("diverge", 8'h10, 4'b0011, 2, 0);
        do_exec("nop", 8'h10, 0, 0, 3'b000, 8'h00);
        step("idle");
        do_exec("sync", 8'h12, 0, 1, 3'b000, 8'h00);
        expect_out("sync1", 8'h06, 4'b1100, 1, 0);
        do_exec("sync", 8'h12, 0, 1, 3'b000, 8'h00);
        expect_out("sync2", 8'h13, 4'hF, 0, 0);

        // Partial block, not-taken and empty-lane branches
        thread_enable = 4'b0011;
        do_exec("br_part", 8'h20, 1, 0, 3'b100, 8'h44);
        expect_out("partial", 8'h44, 4'hF, 0, 0);
        do_exec("br_nt", 8'h44, 1, 0, 3'b010, 8'h77);
        expect_out("not_taken", 8'h45, 4'hF, 0, 0);
        thread_enable = 4'b0000;
        do_exec("br_none", 8'h45, 1, 0, 3'b100, 8'h50);
        expect_out("no_lanes", 8'h50, 4'hF, 0, 0);
        thread_enable = 4'hF;

        // Boundaries
        do_exec("nop_wrap", 8'hFF, 0, 0, 3'b000, 8'h00);
        expect_out("wrap", 8'h00, 4'hF, 0, 0);
        do_exec("sync_mt", 8'h40, 0, 1, 3'b000, 8'h00);
        expect_out("sync_empty", 8'h41, 4'hF, 0, 0);
        enable = 0;
        do_exec("br_dis", 8'h05, 1, 0, 3'b100, 8'h10);
        expect_out("disabled", 8'h41, 4'hF, 0, 0);
        enable = 1;

        // Nested divergence up to overflow
        do_cmp(3'b100, 3'b100, 3'b100, 3'b001);
        do_exec("br_div", 8'h05, 1, 0, 3'b100, 8'h10);
        expect_out("nest1", 8'h10, 4'b0111, 2, 0);
        do_cmp(3'b100, 3'b100, 3'b001, 3'b100);
        do_exec("br_div", 8'h11, 1, 0, 3'b100, 8'h20);
        expect_out("nest2", 8'h20, 4'b0011, 4, 0);
        do_cmp(3'b100, 3'b001, 3'b100, 3'b100);
        do_exec("br_ovf", 8'h30, 1, 0, 3'b100, 8'h60);
        expect_out("overflow", 8'h31, 4'b0011, 4, 1);
        do_exec("sync_br", 8'h32, 1, 1, 3'b100, 8'h60);
        expect_out("sync_prio", 8'h12, 4'b0100, 3, 1);
        step("idle");
        reset = 0; step("reset"); reset = 1;
        expect_out("reset_ovf", 8'h00, 4'hF, 0, 0);

        // NZP cleared by reset: nothing can be taken
        do_exec("br_clr", 8'h07, 1, 0, 3'b111, 8'h70);
        expect_out("nzp_clr", 8'h08, 4'hF, 0, 0);

        // Reset in the middle of a divergence
        do_cmp(3'b100, 3'b100, 3'b001, 3'b001);
        do_exec("br_div", 8'h05, 1, 0, 3'b100, 8'h10);
        expect_out("pre_reset", 8'h10, 4'b0011, 2, 0);
        reset = 0; step("reset"); reset = 1;
        expect_out("mid_reset", 8'h00, 4'hF, 0, 0);
        step("idle");

        cmp_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
